// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding, flag bit positions.
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_AND   = 3'b001;
    localparam logic [2:0] ALU_NOT   = 3'b010;
    localparam logic [2:0] ALU_PASSA = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_SHL   = 3'b101;
    localparam logic [2:0] ALU_SHR   = 3'b110;
    localparam logic [2:0] ALU_MUL   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // FLAGS is packed {N,Z,P,C,V}
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    localparam logic [4:0] FLAGS_RESET = 5'b01000;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift / shift-add multiply engine, one step per cycle after a start pulse.
// The multiplier datapath exists only when ALU_SEQ_MUL_EN is defined.
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
`ifdef ALU_SEQ_MUL_EN
    input  logic [WIDTH-1:0] b,
`endif
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = SHW + 1;

    logic             active_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_next;
    logic [CNT_W-1:0] count_reg;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] mplier_next;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
`endif

    always_comb begin
        work_next = work_reg;
`ifdef ALU_SEQ_MUL_EN
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
`endif
        case (op_reg)
            ALU_SHL: work_next = work_reg << 1;
            ALU_SHR: work_next = work_reg >> 1;
`ifdef ALU_SEQ_MUL_EN
            // work_reg is the multiplicand, shifted up as the multiplier is consumed LSB-first
            ALU_MUL: begin
                acc_next    = acc_reg + (mplier_reg[0] ? work_reg : '0);
                work_next   = work_reg << 1;
                mplier_next = mplier_reg >> 1;
            end
`endif
            default: ;
        endcase
    end

    // The final step is exposed combinationally so the top can register it in the same edge.
    always_comb begin
        done   = active_reg & (count_reg == CNT_W'(1));
        result = work_next;
`ifdef ALU_SEQ_MUL_EN
        if (op_reg == ALU_MUL) begin
            result = acc_next;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            op_reg     <= '0;
            work_reg   <= '0;
            count_reg  <= '0;
`ifdef ALU_SEQ_MUL_EN
            mplier_reg <= '0;
            acc_reg    <= '0;
`endif
        end else if (start) begin
            active_reg <= 1'b1;
            op_reg     <= op;
            work_reg   <= a;
`ifdef ALU_SEQ_MUL_EN
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= (op == ALU_MUL) ? CNT_W'(WIDTH) : {1'b0, amt};
`else
            count_reg  <= {1'b0, amt};
`endif
        end else if (active_reg) begin
            work_reg  <= work_next;
`ifdef ALU_SEQ_MUL_EN
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
`endif
            count_reg <= count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1)) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: FSM, single-cycle ops, registered result and NZPCV flags.
// Define ALU_SEQ_MUL_EN to enable the iterative multiplier for opcode 111.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       ALUK,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic [4:0]       FLAGS
);

    state_t           state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic [4:0]       flags_reg;

    logic             accept;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [WIDTH-1:0] single_res;
    logic             single_c;
    logic             single_v;
    logic             launch_iter;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    function automatic logic [4:0] flags_of(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        logic [4:0] f;
        f         = '0;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_P] = ~r[WIDTH-1] & (r != '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign IN_READY  = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & OUT_READY);
    assign accept    = IN_VALID & IN_READY;
    assign OUT_VALID = out_valid_reg;
    assign RESULT    = result_reg;
    assign FLAGS     = flags_reg;

    // SUB reuses the ADD adder as A + ~B + 1, so C comes out as NOT borrow.
    always_comb begin
        is_sub = (ALUK == ALU_SUB);
        b_eff  = is_sub ? ~OP_B : OP_B;
        sum    = {1'b0, OP_A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        add_v  = (OP_A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != OP_A[WIDTH-1]);
    end

    always_comb begin
        single_res  = '0;
        single_c    = 1'b0;
        single_v    = 1'b0;
        launch_iter = 1'b0;
        case (ALUK)
            ALU_ADD, ALU_SUB: begin
                single_res = sum[WIDTH-1:0];
                single_c   = sum[WIDTH];
                single_v   = add_v;
            end
            ALU_AND:   single_res = OP_A & OP_B;
            ALU_NOT:   single_res = ~OP_A;
            ALU_PASSA: single_res = OP_A;
            ALU_SHL, ALU_SHR: begin
                if (OP_B[SHW-1:0] == '0) begin
                    single_res = OP_A;
                end else begin
                    launch_iter = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ALU_MUL:   launch_iter = 1'b1;
`else
            ALU_MUL:   single_res = '0;
`endif
            default: ;
        endcase
    end

    assign iter_start = accept & launch_iter;

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (CLK),
        .rst_n  (RST_N),
        .start  (iter_start),
        .op     (ALUK),
        .a      (OP_A),
        .amt    (OP_B[SHW-1:0]),
`ifdef ALU_SEQ_MUL_EN
        .b      (OP_B),
`endif
        .done   (iter_done),
        .result (iter_result)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= FLAGS_RESET;
        end else begin
            case (state_reg)
                ST_BUSY: begin
                    if (iter_done) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= iter_result;
                        flags_reg     <= flags_of(iter_result, 1'b0, 1'b0);
                    end
                end
                default: begin
                    // IDLE, or DONE being drained; a simultaneous accept restarts directly.
                    if (accept) begin
                        if (launch_iter) begin
                            state_reg     <= ST_BUSY;
                            out_valid_reg <= 1'b0;
                        end else begin
                            state_reg     <= ST_DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= single_res;
                            flags_reg     <= flags_of(single_res, single_c, single_v);
                        end
                    end else if ((state_reg == ST_DONE) && OUT_READY) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed cases plus randomized traffic vs. a behavioural model.
module tb_alu_seq;
    import alu_pkg::*;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint MOD = 65536;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [2:0]  ALUK = '0;
    logic [15:0] OP_A = '0;
    logic [15:0] OP_B = '0;
    logic        IN_READY;
    logic        OUT_VALID;
    logic [15:0] RESULT;
    logic [4:0]  FLAGS;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // model state
    bit          pend = 1'b0;
    bit          model_ok = 1'b0;
    bit          just_reset = 1'b0;
    longint      m_res = 0;
    logic [4:0]  m_fl = '0;
    int          m_due = 0;

    alu_seq #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALUK      (ALUK),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .FLAGS     (FLAGS)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: what the result, flags and latency must be, from plain integer arithmetic.
    function automatic void ref_op(input logic [2:0] op, input longint a, input longint b,
                                   output longint res, output logic [4:0] fl, output int lat);
        longint sa, sb, s;
        int     amt;
        bit     c, v;
        sa  = (a >= 32768) ? a - MOD : a;
        sb  = (b >= 32768) ? b - MOD : b;
        amt = int'(b % 16);
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        res = 0;
        case (op)
            ALU_ADD: begin
                res = (a + b) % MOD;
                c   = (a + b) >= MOD;
                s   = sa + sb;
                v   = (s > 32767) || (s < -32768);
            end
            ALU_AND:   res = a & b;
            ALU_NOT:   res = (MOD - 1) - a;
            ALU_PASSA: res = a;
            ALU_SUB: begin
                res = (a - b + MOD) % MOD;
                c   = a >= b;
                s   = sa - sb;
                v   = (s > 32767) || (s < -32768);
            end
            ALU_SHL: begin res = (a << amt) % MOD; lat = 1 + amt; end
            ALU_SHR: begin res = a >> amt;         lat = 1 + amt; end
            default: begin
                if (MUL_EN) begin res = (a * b) % MOD; lat = 17; end
                else        begin res = 0;             lat = 1;  end
            end
        endcase
        fl = {res >= 32768, res == 0, (res != 0) && (res < 32768), c, v};
    endfunction

    // Cycle-by-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge CLK) begin
        bit         ev, er;
        longint     r;
        logic [4:0] f;
        int         l;
        ev = pend && (cyc >= m_due);
        er = !pend || (ev && OUT_READY);
        if (model_ok) begin
            chk("out_valid", OUT_VALID, ev);
            chk("in_ready", IN_READY, er);
            if (ev) begin
                chk("result", RESULT, m_res);
                chk("flags", FLAGS, m_fl);
            end
            if (just_reset) begin
                chk("rst_result", RESULT, 0);
                chk("rst_flags", FLAGS, 5'b01000);
            end
        end
        if (!RST_N) begin
            pend       = 1'b0;
            just_reset = 1'b1;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            just_reset = 1'b0;
            if (ev && OUT_READY) pend = 1'b0;
            if (IN_VALID && er) begin
                ref_op(ALUK, OP_A, OP_B, r, f, l);
                pend  = 1'b1;
                m_res = r;
                m_fl  = f;
                m_due = cyc + l;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bit got;
        got = 1'b0;
        @(posedge CLK); #1;
        ALUK = op; OP_A = a; OP_B = b; IN_VALID = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (IN_READY === 1'b1) begin got = 1'b1; break; end
            @(posedge CLK); #1;
        end
        chk("accepted", got, 1);
        acc_cyc = cyc;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic [15:0] er, input logic [4:0] ef, input int el);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) begin got = 1'b1; break; end
        end
        chk({nm, "_seen"}, got, 1);
        chk({nm, "_lat"}, cyc - acc_cyc, el);
        chk({nm, "_res"}, RESULT, er);
        chk({nm, "_flags"}, FLAGS, ef);
        $display("txn %s: result=0x%04h flags=%05b latency=%0d", nm, RESULT, FLAGS, cyc - acc_cyc);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 6)
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        longint     r;
        logic [4:0] f;
        int         l;
        bit         took;

        // Pin the model to hand-computed values.
        ref_op(ALU_ADD, 16'h7FFF, 16'h0001, r, f, l);
        chk("pin_add_res", r, 16'h8000);
        chk("pin_add_fl", f, 5'b10001);
        ref_op(ALU_SUB, 16'h0003, 16'h0005, r, f, l);
        chk("pin_sub_res", r, 16'hFFFE);
        chk("pin_sub_fl", f, 5'b10000);
        ref_op(ALU_SHL, 16'h0001, 16'h0004, r, f, l);
        chk("pin_shl_lat", l, 5);
        ref_op(ALU_MUL, 16'h0003, 16'h0005, r, f, l);
        chk("pin_mul_res", r, MUL_EN ? 15 : 0);

        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("reset_valid", OUT_VALID, 0);
        chk("reset_ready", IN_READY, 1);
        chk("reset_result", RESULT, 0);
        chk("reset_flags", FLAGS, 5'b01000);

        issue(ALU_ADD, 16'h7FFF, 16'h0001); wait_result("add_ovf", 16'h8000, 5'b10001, 1);
        issue(ALU_SUB, 16'h0005, 16'h0005); wait_result("sub_eq",  16'h0000, 5'b01010, 1);
        issue(ALU_SUB, 16'h0003, 16'h0005); wait_result("sub_neg", 16'hFFFE, 5'b10000, 1);
        issue(ALU_SHL, 16'h0001, 16'h0004);
        @(negedge CLK);
        chk("shl_busy_ready", IN_READY, 0);
        wait_result("shl4", 16'h0010, 5'b00100, 5);
        issue(ALU_SHR, 16'h8000, 16'h0000); wait_result("shr0", 16'h8000, 5'b10000, 1);
        issue(ALU_MUL, 16'h0003, 16'h0005);
        wait_result("mul", MUL_EN ? 16'h000F : 16'h0000, MUL_EN ? 5'b00100 : 5'b01000, MUL_EN ? 17 : 1);

        // Backpressure, then drain with a simultaneous accept.
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        issue(ALU_ADD, 16'h0001, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("bp_hold_res", RESULT, 16'h0003);
            chk("bp_hold_ready", IN_READY, 0);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1; IN_VALID = 1'b1; ALUK = ALU_AND; OP_A = 16'h00FF; OP_B = 16'h0F0F;
        @(negedge CLK);
        chk("bp_same_cycle_ready", IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bp_and_valid", OUT_VALID, 1);
        chk("bp_and_res", RESULT, 16'h000F);
        $display("txn backpressure: result=0x%04h flags=%05b", RESULT, FLAGS);

        // Reset in the sixth busy cycle of a long operation.
        if (MUL_EN) issue(ALU_MUL, 16'h0003, 16'h0005);
        else        issue(ALU_SHL, 16'h0003, 16'h000F);
        repeat (5) begin @(posedge CLK); #1; end
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("midrst_valid", OUT_VALID, 0);
        chk("midrst_res", RESULT, 0);
        chk("midrst_flags", FLAGS, 5'b01000);
        chk("midrst_ready", IN_READY, 1);
        $display("txn mid_reset: valid=%0b result=0x%04h flags=%05b", OUT_VALID, RESULT, FLAGS);
        repeat (25) @(negedge CLK);

        // Randomized traffic with random backpressure and one reset.
        took = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(posedge CLK); #1;
            if (!IN_VALID || took) begin
                IN_VALID = ($urandom % 3) != 0;
                ALUK     = 3'($urandom);
                OP_A     = pick();
                OP_B     = pick();
            end
            OUT_READY = ($urandom % 4) != 0;
            RST_N     = (i != 1200);
            @(negedge CLK);
            took = IN_VALID && (IN_READY === 1'b1) && RST_N;
            if (took) $display("txn rand %0d: op=%0d a=0x%04h b=0x%04h", i, ALUK, OP_A, OP_B);
        end
        @(posedge CLK); #1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        RST_N     = 1'b1;
        repeat (30) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
